// File: rtl/loopback_pkg.sv
// Shared definitions for the HPIO loopback RX-side monitors.
//   LB_DATA_W   : default loopback word width
//   chk_state_e : checker lock state (SEEK / LOCKED)
//   sat_add     : clamped add, used as the saturating increment/accumulate
//   popcount    : number of set bits in a word (up to 64 bits)
package loopback_pkg;

    localparam int unsigned LB_DATA_W = 8;

    typedef enum logic {
        SEEK   = 1'b0,
        LOCKED = 1'b1
    } chk_state_e;

    // Operands are zero-extended to 64 bits by the caller; max_val is the
    // all-ones value of the caller's counter width.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input logic [63:0] max_val);
        logic [64:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_val}) begin
            return max_val;
        end
        return sum[63:0];
    endfunction

    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + {6'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating accumulator with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear_i    : zero the count (has priority over en_i)
//   en_i       : add add_i this cycle
//   add_i      : amount to add; result clamps at all-ones
//   count_o    : current count
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] add_i,
    output logic [WIDTH-1:0] count_o
);
    import loopback_pkg::*;

    localparam logic [63:0] MaxVal = 64'({WIDTH{1'b1}});

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = WIDTH'(sat_add(64'(count_q), 64'(add_i), MaxVal));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/counter_checker.sv
// Receive-side checker for the incrementing-counter loopback pattern.
// Locks after LOCK_CNT consecutive +1 steps, then checks each valid word
// against a free-running expected value; drops lock after UNLOCK_CNT
// consecutive word errors. Latency from input sample to status is 2 cycles.
//   clk, rst_n    : fabric clock, asynchronous active-low reset
//   data_in       : received word, qualified by data_valid
//   clear         : synchronous clear of counters and lock_lost
//   locked        : checker is LOCKED
//   err_pulse     : one-cycle pulse per erroneous word
//   err_count     : word errors (saturating)
//   bit_err_count : accumulated bit errors (saturating)
//   word_count    : words checked while LOCKED (saturating)
//   lock_lost     : sticky, set on LOCKED->SEEK
//   expected      : current expected word
module counter_checker #(
    parameter int unsigned DATA_W     = loopback_pkg::LB_DATA_W,
    parameter int unsigned LOCK_CNT   = 16,
    parameter int unsigned UNLOCK_CNT = 4,
    parameter int unsigned ERR_CNT_W  = 32,
    parameter int unsigned WORD_CNT_W = 48
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  data_valid,
    input  logic                  clear,
    output logic                  locked,
    output logic                  err_pulse,
    output logic [ERR_CNT_W-1:0]  err_count,
    output logic [ERR_CNT_W-1:0]  bit_err_count,
    output logic [WORD_CNT_W-1:0] word_count,
    output logic                  lock_lost,
    output logic [DATA_W-1:0]     expected
);
    import loopback_pkg::*;

    localparam logic [DATA_W-1:0] DataOne   = DATA_W'(1);
    localparam logic [7:0]        LockCnt8  = 8'(LOCK_CNT);
    localparam logic [7:0]        UnlockCnt = 8'(UNLOCK_CNT);

    // Stage 0: input capture
    logic              v_q;
    logic [DATA_W-1:0] d_q;

    // Stage 1 state
    chk_state_e        state_q, state_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              prev_ok_q, prev_ok_d;
    logic [7:0]        match_run_q, match_run_d;
    logic [7:0]        miss_run_q, miss_run_d;
    logic [DATA_W-1:0] expected_q, expected_d;
    logic              err_pulse_q, err_pulse_d;
    logic              lock_lost_q, lock_lost_d;

    logic err_inc;
    logic word_inc;

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        prev_ok_d   = prev_ok_q;
        match_run_d = match_run_q;
        miss_run_d  = miss_run_q;
        expected_d  = expected_q;
        err_pulse_d = 1'b0;
        lock_lost_d = lock_lost_q;
        err_inc     = 1'b0;
        word_inc    = 1'b0;

        if (v_q) begin
            unique case (state_q)
                SEEK: begin
                    prev_d    = d_q;
                    prev_ok_d = 1'b1;
                    if (prev_ok_q && (d_q == prev_q + DataOne)) begin
                        if (match_run_q + 8'd1 == LockCnt8) begin
                            state_d     = LOCKED;
                            expected_d  = d_q + DataOne;
                            match_run_d = '0;
                        end else begin
                            match_run_d = match_run_q + 8'd1;
                        end
                    end else begin
                        match_run_d = '0;
                    end
                end
                LOCKED: begin
                    word_inc = 1'b1;
                    // Free-running: a single corrupted word costs exactly one error.
                    expected_d = expected_q + DataOne;
                    if (d_q == expected_q) begin
                        miss_run_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_inc     = 1'b1;
                        if (miss_run_q + 8'd1 == UnlockCnt) begin
                            state_d     = SEEK;
                            lock_lost_d = 1'b1;
                            prev_ok_d   = 1'b0;
                            miss_run_d  = '0;
                        end else begin
                            miss_run_d = miss_run_q + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (clear) begin
            lock_lost_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q         <= 1'b0;
            d_q         <= '0;
            state_q     <= SEEK;
            prev_q      <= '0;
            prev_ok_q   <= 1'b0;
            match_run_q <= '0;
            miss_run_q  <= '0;
            expected_q  <= '0;
            err_pulse_q <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            v_q         <= data_valid;
            d_q         <= data_in;
            state_q     <= state_d;
            prev_q      <= prev_d;
            prev_ok_q   <= prev_ok_d;
            match_run_q <= match_run_d;
            miss_run_q  <= miss_run_d;
            expected_q  <= expected_d;
            err_pulse_q <= err_pulse_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    sat_counter #(
        .WIDTH (ERR_CNT_W)
    ) u_err_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (clear),
        .en_i    (err_inc),
        .add_i   (ERR_CNT_W'(1)),
        .count_o (err_count)
    );

    // DATA_W is assumed to be at most 64 for the popcount.
    sat_counter #(
        .WIDTH (ERR_CNT_W)
    ) u_bit_err_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (clear),
        .en_i    (err_inc),
        .add_i   (ERR_CNT_W'(popcount(64'(d_q ^ expected_q)))),
        .count_o (bit_err_count)
    );

    sat_counter #(
        .WIDTH (WORD_CNT_W)
    ) u_word_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (clear),
        .en_i    (word_inc),
        .add_i   (WORD_CNT_W'(1)),
        .count_o (word_count)
    );

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;
    assign lock_lost = lock_lost_q;
    assign expected  = expected_q;

endmodule

// File: tb/tb_counter_checker.sv
module tb_counter_checker;

    localparam int     LockCnt    = 16;
    localparam int     UnlockCnt  = 4;
    localparam longint ErrMaxBig  = 64'hFFFF_FFFF;
    localparam longint WordMaxBig = (64'd1 << 48) - 1;
    localparam longint ErrMaxSm   = 31;
    localparam longint WordMaxSm  = 255;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       data_valid = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic        b_locked, b_pulse, b_lost;
    logic [31:0] b_err, b_bit;
    logic [47:0] b_words;
    logic [7:0]  b_exp;

    logic       s_locked, s_pulse, s_lost;
    logic [4:0] s_err, s_bit;
    logic [7:0] s_words;
    logic [7:0] s_exp;

    counter_checker u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .clear         (clear),
        .locked        (b_locked),
        .err_pulse     (b_pulse),
        .err_count     (b_err),
        .bit_err_count (b_bit),
        .word_count    (b_words),
        .lock_lost     (b_lost),
        .expected      (b_exp)
    );

    // Narrow counters so saturation is reached within the run.
    counter_checker #(
        .ERR_CNT_W  (5),
        .WORD_CNT_W (8)
    ) u_small (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .clear         (clear),
        .locked        (s_locked),
        .err_pulse     (s_pulse),
        .err_count     (s_err),
        .bit_err_count (s_bit),
        .word_count    (s_words),
        .lock_lost     (s_lost),
        .expected      (s_exp)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Counters are kept as unbounded totals since the last clear/reset;
    // a saturating accumulator always reads min(total, max).
    bit     m_locked = 0, m_have_last = 0, m_pulse = 0, m_lost = 0;
    int     m_last = 0, m_streak = 0, m_exp = 0, m_misses = 0;
    longint m_errs = 0, m_bits = 0, m_words = 0;
    bit     m_v = 0;
    int     m_d = 0;
    bit     chk_en = 0;

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_locked = 0; m_have_last = 0; m_pulse = 0; m_lost = 0;
            m_last = 0; m_streak = 0; m_exp = 0; m_misses = 0;
            m_errs = 0; m_bits = 0; m_words = 0; m_v = 0; m_d = 0;
        end else begin
            m_pulse = 0;
            if (m_v) begin
                if (!m_locked) begin
                    if (m_have_last && m_d == (m_last + 1) % 256) begin
                        m_streak++;
                        if (m_streak == LockCnt) begin
                            m_locked = 1;
                            m_exp = (m_d + 1) % 256;
                            m_streak = 0;
                        end
                    end else begin
                        m_streak = 0;
                    end
                    m_last = m_d;
                    m_have_last = 1;
                end else begin
                    m_words++;
                    if (m_d != m_exp) begin
                        m_pulse = 1;
                        m_errs++;
                        m_bits += $countones(8'(m_d ^ m_exp));
                        m_misses++;
                        if (m_misses == UnlockCnt) begin
                            m_locked = 0;
                            m_lost = 1;
                            m_have_last = 0;
                            m_misses = 0;
                        end
                    end else begin
                        m_misses = 0;
                    end
                    m_exp = (m_exp + 1) % 256;
                end
            end
            if (clear) begin
                m_errs = 0; m_bits = 0; m_words = 0; m_lost = 0;
            end
            m_v = data_valid;
            m_d = int'(data_in);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("locked",        b_locked, m_locked);
            check("err_pulse",     b_pulse,  m_pulse);
            check("err_count",     b_err,    sat(m_errs, ErrMaxBig));
            check("bit_err_count", b_bit,    sat(m_bits, ErrMaxBig));
            check("word_count",    b_words,  sat(m_words, WordMaxBig));
            check("lock_lost",     b_lost,   m_lost);
            check("expected",      b_exp,    m_exp);
            check("sm_locked",     s_locked, m_locked);
            check("sm_err_pulse",  s_pulse,  m_pulse);
            check("sm_err_count",  s_err,    sat(m_errs, ErrMaxSm));
            check("sm_bit_err",    s_bit,    sat(m_bits, ErrMaxSm));
            check("sm_word_count", s_words,  sat(m_words, WordMaxSm));
            check("sm_lock_lost",  s_lost,   m_lost);
            check("sm_expected",   s_exp,    m_exp);
        end
    end

    // ---------------- stimulus ----------------
    int cnt = 0;

    task automatic send(input bit v, input int d, input bit clr);
        @(posedge clk);
        #1;
        data_valid = v;
        data_in    = 8'(d);
        clear      = clr;
    endtask

    task automatic send_cnt();
        send(1'b1, cnt, 1'b0);
        cnt = (cnt + 1) % 256;
    endtask

    int r, d, burst;
    bit v, clr;

    initial begin
        burst = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Reset only, no valid data
        repeat (10) send(1'b0, 0, 1'b0);
        check("idle_locked", b_locked, 0);
        check("idle_err", b_err, 0);
        check("idle_words", b_words, 0);
        check("idle_expected", b_exp, 0);

        // Counting pattern from 0x00: lock on 0x10
        repeat (17) send_cnt();
        send_cnt();
        check("prelock_locked", b_locked, 0);
        send_cnt();
        check("lock_locked", b_locked, 1);
        check("lock_expected", b_exp, 8'h11);
        check("lock_words", b_words, 0);
        repeat (280) send_cnt();
        check("wrap_err", b_err, 0);
        check("wrap_words", b_words, 280);
        check("wrap_locked", b_locked, 1);

        // Single corrupted word: 0x45 replaced by 0x47
        while (cnt != 8'h45) send_cnt();
        send(1'b1, 8'h47, 1'b0);
        cnt = 8'h46;
        send_cnt();
        send_cnt();
        check("single_pulse", b_pulse, 1);
        check("single_err", b_err, 1);
        check("single_bits", b_bit, 1);
        check("single_locked", b_locked, 1);
        send_cnt();
        check("single_next_clean", b_pulse, 0);
        check("single_err_hold", b_err, 1);

        // Stride 2 after 0x50: four errors drop lock
        while (cnt != 8'h51) send_cnt();
        for (int k = 1; k <= 4; k++) send(1'b1, 8'h50 + 2 * k, 1'b0);
        cnt = 8'h60;
        send_cnt();
        send_cnt();
        check("stride_locked", b_locked, 0);
        check("stride_lost", b_lost, 1);
        check("stride_err", b_err, 5);
        repeat (15) send_cnt();
        send_cnt();
        check("relock_early", b_locked, 0);
        send_cnt();
        check("relock_locked", b_locked, 1);

        // Clear, then gapped valid words
        repeat (3) send(1'b0, 0, 1'b0);
        send(1'b0, 0, 1'b1);
        send(1'b0, 0, 1'b0);
        check("clear_words", b_words, 0);
        check("clear_lost", b_lost, 0);
        for (int i = 0; i < 20; i++) begin
            send_cnt();
            send(1'b0, $urandom_range(0, 255), 1'b0);
            send(1'b0, $urandom_range(0, 255), 1'b0);
        end
        repeat (3) send(1'b0, 0, 1'b0);
        check("gap_words", b_words, 20);
        check("gap_err", b_err, 0);

        // Error coincident with clear
        send(1'b1, cnt ^ 8'h10, 1'b0);
        cnt = (cnt + 1) % 256;
        send(1'b1, cnt, 1'b1);
        cnt = (cnt + 1) % 256;
        send_cnt();
        check("clrerr_pulse", b_pulse, 1);
        check("clrerr_err", b_err, 0);
        check("clrerr_bits", b_bit, 0);

        // Asynchronous reset mid-stream
        repeat (3) send_cnt();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_locked", b_locked, 0);
        check("arst_words", b_words, 0);
        check("arst_expected", b_exp, 0);
        data_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (16) send_cnt();
        send(1'b0, 0, 1'b0);
        send(1'b0, 0, 1'b0);
        check("arst_relock_early", b_locked, 0);
        send_cnt();
        send(1'b0, 0, 1'b0);
        send(1'b0, 0, 1'b0);
        check("arst_relock", b_locked, 1);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            r   = $urandom_range(0, 99);
            v   = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 599) == 0);
            if (burst > 0) begin
                d = $urandom_range(0, 255);
                burst--;
            end else if (r < 6) begin
                d = cnt ^ (1 << $urandom_range(0, 7));
            end else if (r == 6) begin
                burst = $urandom_range(3, 6);
                d = $urandom_range(0, 255);
            end else begin
                d = cnt;
            end
            send(v, d, clr);
            if (v) cnt = (cnt + 1) % 256;
        end
        repeat (4) send(1'b0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog: got timeout want finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
